avalon_mem_if_arb2: RTL
=======================

# avalon_mem_if_arb2

Two-to-one arbiter that shares a single Avalon-MM local-memory port on the FIU side between two AFU-side requesters. It sits between the platform memory port and two AFU clients, which may be two engines or one engine plus a debug/DMA client. Its jobs are round-robin command arbitration, locking the port for the whole of a write burst, and tracking outstanding reads so that every returned read beat reaches the requester that issued it.

## Interface
Parameters:
- ADDR_WIDTH, 27, word address width
- DATA_WIDTH, 512, data bus width; byteenable width is DATA_WIDTH/8
- BURST_CNT_WIDTH, 7, burstcount width
- MAX_RD_OUTSTANDING, 64, depth of the read-owner FIFO, in read commands (not beats); power of 2, minimum 2

Ports (index [i] selects requester i, i = 0 or 1):
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- afu_read  in  [2]  read request per requester
- afu_write  in  [2]  write request / write beat per requester
- afu_address  in  [2][ADDR_WIDTH]  address
- afu_burstcount  in  [2][BURST_CNT_WIDTH]  burst length
- afu_writedata  in  [2][DATA_WIDTH]  write data
- afu_byteenable  in  [2][DATA_WIDTH/8]  byte enables
- afu_waitrequest  out  [2]  stall to requester
- afu_readdata  out  DATA_WIDTH  read data, broadcast to both requesters
- afu_readdatavalid  out  [2]  read beat valid, asserted only toward the owning requester
- fiu_read, fiu_write  out  1 each  command to memory
- fiu_address, fiu_burstcount, fiu_writedata, fiu_byteenable  out  widths as above  muxed command fields
- fiu_waitrequest  in  1  memory stall
- fiu_readdata  in  DATA_WIDTH  read data from memory
- fiu_readdatavalid  in  1  read beat valid from memory
- err_unexpected_rd  out  1  sticky flag: read beat arrived while no read was outstanding

## Operation
- **Eligibility.**
  - A requester is eligible when it asserts read or write.
  - A read is ineligible while the owner FIFO is full.
- **Grant selection, in priority order:**
  1. Write-burst lock owner, if a lock is active.
  2. Held owner: a command was presented to the FIU and stalled by fiu_waitrequest.
  3. The single eligible requester.
  4. If both are eligible, the requester that is not last_served.
- **Command muxing.**
  - The granted requester's fields drive the fiu_* outputs combinationally.
  - fiu_read and fiu_write are 0 when there is no grant.
- **Waitrequest to requesters.**
  - afu_waitrequest[i] = !grant[i] | fiu_waitrequest | (afu_read[i] & fifo_full).
  - While a requester's read is blocked by a full FIFO, fiu_read is not driven for it.
- **Command accept.** A command is accepted when fiu_read or fiu_write is asserted and fiu_waitrequest is 0 in the same cycle.
- **Write bursts.**
  - Accepting the first beat of a write with burstcount N > 1 sets lock_owner and loads wr_beats_left = N-1.
  - Each later accepted beat decrements wr_beats_left; the lock clears when it reaches 0.
  - Read commands from the lock owner are not accepted during its lock.
- **Reads.**
  - Each accepted read pushes {owner, burstcount} into the owner FIFO.
- **Read return.**
  - fiu_readdata is forwarded to afu_readdata.
  - afu_readdatavalid[head.owner] = fiu_readdatavalid.
  - A beat counter counts returned beats against head.burstcount; the FIFO pops on the last beat and the counter resets to 0.
- **last_served.** Updates to the requester of each accepted command: a read, or the first beat of a write.
- **Arithmetic.**
  - burstcount 0 is treated as 1.
  - Burst counters are BURST_CNT_WIDTH bits wide.
  - FIFO occupancy uses a log2(MAX_RD_OUTSTANDING)+1 bit count; pointers wrap modulo the depth.

## Timing
- **Latency.** Command path and read-return path are both combinational: 0 cycles added latency.
- **Sequential state.** All state is registered on clk: grant hold, lock, last_served, FIFO, beat counter, error flag.
- **Reset values.**
  - fiu_read = 0, fiu_write = 0.
  - afu_waitrequest = 2'b11.
  - afu_readdatavalid = 0.
  - err_unexpected_rd = 0.
  - FIFO empty, lock cleared, beat counter 0.
  - last_served = 1, so requester 0 wins the first tie.
- **Reset mid-operation.** Outstanding reads and any open burst are discarded. A later fiu_readdatavalid seen with the FIFO empty sets err_unexpected_rd and the beat is dropped; no afu_readdatavalid is asserted.
- **Full boundary.** fifo_full uses the registered count, with no bypass: a pop in the same cycle does not admit a push until the next cycle.
- **Simultaneous push and pop.** Count is unchanged.
- **Stability.** The FIU command stays stable while fiu_waitrequest = 1; the grant does not change.

## Test plan
- **Simultaneous reads.** Reset, then both requesters read burstcount 1 in cycle 0 with fiu_waitrequest = 0 → req0 accepted in cycle 0, req1 in cycle 1. The first returned beat raises afu_readdatavalid = 2'b01, the second 2'b10.
- **Write-burst lock.** req1 write burstcount 4; req0 writes from the same cycle; fiu_waitrequest = 1 on beat 2 → all 4 req1 beats reach the FIU uninterrupted, and req0's first beat is accepted in the cycle after req1's 4th.
- **Read-return routing.** req0 read burstcount 8, then req1 read burstcount 2; memory returns 10 beats with gaps → beats 1-8 go to req0 only, beats 9-10 to req1 only, and the FIFO ends empty.
- **FIFO full.** MAX_RD_OUTSTANDING = 4; req0 issues 5 reads with no returns → the 5th is held with afu_waitrequest[0] = 1, while a req1 write is still accepted. After the last beat of the first read, the 5th read is accepted one cycle later.
- **Stall stability.** fiu_waitrequest held 3 cycles with req0's read presented and req1 requesting → fiu_address and fiu_read stay constant, req0 is accepted in cycle 3, and req1 follows in cycle 4.
- **Reset mid-burst.** reset_n deasserted during beat 2 of a 4-beat write → all outputs return to their reset values immediately. After reset, one fiu_readdatavalid → err_unexpected_rd = 1 and afu_readdatavalid = 0.

Source files
------------

// File: rtl/avalon_mem_if_arb2.sv
// -----------------------------------------------------------------------------
// avalon_mem_if_arb2
//
// Shares one Avalon-MM local-memory port on the FIU side between two AFU-side
// requesters. It does three things:
//   - round-robin command arbitration, with a grant that is held while the FIU
//     stalls a presented command;
//   - locks the port to one requester for the whole of a multi-beat write;
//   - keeps an in-order FIFO of outstanding read commands, so that every
//     returned read beat is steered to the requester that issued it.
// The command path and the read-return path are both combinational.
//
// Ports
//   clk, reset_n        clock and asynchronous active-low reset
//   afu_*   [i]         requester i command inputs and waitrequest output
//   afu_readdata        read data, broadcast to both requesters
//   afu_readdatavalid   read beat valid, raised only toward the owning requester
//   fiu_*               muxed command to memory, plus read data and stall from it
//   err_unexpected_rd   sticky flag: a read beat arrived with no read outstanding
// -----------------------------------------------------------------------------
module avalon_mem_if_arb2 #(
  parameter int ADDR_WIDTH         = 27,
  parameter int DATA_WIDTH         = 512,
  parameter int BURST_CNT_WIDTH    = 7,
  parameter int MAX_RD_OUTSTANDING = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [1:0]                           afu_read,
  input  logic [1:0]                           afu_write,
  input  logic [1:0][ADDR_WIDTH-1:0]           afu_address,
  input  logic [1:0][BURST_CNT_WIDTH-1:0]      afu_burstcount,
  input  logic [1:0][DATA_WIDTH-1:0]           afu_writedata,
  input  logic [1:0][DATA_WIDTH/8-1:0]         afu_byteenable,
  output logic [1:0]                           afu_waitrequest,
  output logic [DATA_WIDTH-1:0]                afu_readdata,
  output logic [1:0]                           afu_readdatavalid,
  output logic                                 fiu_read,
  output logic                                 fiu_write,
  output logic [ADDR_WIDTH-1:0]                fiu_address,
  output logic [BURST_CNT_WIDTH-1:0]           fiu_burstcount,
  output logic [DATA_WIDTH-1:0]                fiu_writedata,
  output logic [DATA_WIDTH/8-1:0]              fiu_byteenable,
  input  logic                                 fiu_waitrequest,
  input  logic [DATA_WIDTH-1:0]                fiu_readdata,
  input  logic                                 fiu_readdatavalid,
  output logic                                 err_unexpected_rd
);

  localparam int PTR_W = $clog2(MAX_RD_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]           FIFO_DEPTH = CNT_W'(MAX_RD_OUTSTANDING);
  localparam logic [CNT_W-1:0]           CNT_ONE    = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]           PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_CNT_WIDTH-1:0] BC_ONE     = {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};

  // A burstcount of 0 is handled as a single-beat transfer.
  function automatic logic [BURST_CNT_WIDTH-1:0] eff_burst(input logic [BURST_CNT_WIDTH-1:0] bc);
    eff_burst = (bc == {BURST_CNT_WIDTH{1'b0}}) ? BC_ONE : bc;
  endfunction

  // Registered state
  logic                       lock_q, lock_d;
  logic                       lock_owner_q, lock_owner_d;
  logic [BURST_CNT_WIDTH-1:0] wr_left_q, wr_left_d;
  logic                       hold_q, hold_d;
  logic                       hold_owner_q, hold_owner_d;
  logic                       last_served_q, last_served_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [BURST_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                       err_q, err_d;

  // Read-owner FIFO storage (data only, validity tracked by cnt_q)
  logic                       fifo_owner_mem [MAX_RD_OUTSTANDING];
  logic [BURST_CNT_WIDTH-1:0] fifo_bc_mem    [MAX_RD_OUTSTANDING];

  // Combinational helpers
  logic                       fifo_full_s, fifo_empty_s;
  logic [1:0]                 elig_s;
  logic                       gnt_vld_s, gnt_idx_s;
  logic                       sel_read_s, sel_write_s, cmd_s;
  logic                       rd_acc_s, wr_acc_s;
  logic                       head_owner_s;
  logic [BURST_CNT_WIDTH-1:0] head_len_s;
  logic                       rd_beat_s, pop_s;

  // Grant selection: lock owner, then stalled owner, then round robin.
  // The grant is forced off while reset is asserted so that every output
  // shows its idle value immediately.
  always_comb begin
    fifo_full_s  = (cnt_q == FIFO_DEPTH);
    fifo_empty_s = (cnt_q == {CNT_W{1'b0}});
    elig_s       = afu_write | (afu_read & {2{~fifo_full_s}});
    gnt_vld_s    = 1'b0;
    gnt_idx_s    = 1'b0;
    if (!reset_n) begin
      gnt_vld_s = 1'b0;
    end else if (lock_q) begin
      gnt_vld_s = 1'b1;
      gnt_idx_s = lock_owner_q;
    end else if (hold_q) begin
      gnt_vld_s = 1'b1;
      gnt_idx_s = hold_owner_q;
    end else begin
      case (elig_s)
        2'b01: begin gnt_vld_s = 1'b1; gnt_idx_s = 1'b0; end
        2'b10: begin gnt_vld_s = 1'b1; gnt_idx_s = 1'b1; end
        2'b11: begin gnt_vld_s = 1'b1; gnt_idx_s = ~last_served_q; end
        default: begin gnt_vld_s = 1'b0; gnt_idx_s = 1'b0; end
      endcase
    end
  end

  // Command mux toward the FIU and waitrequest back to the requesters.
  // A read is withheld while the FIFO is full or while its requester holds
  // a write lock; the requester then sees waitrequest.
  always_comb begin
    sel_read_s     = afu_read[gnt_idx_s];
    sel_write_s    = afu_write[gnt_idx_s];
    fiu_write      = gnt_vld_s & sel_write_s;
    fiu_read       = gnt_vld_s & sel_read_s & ~sel_write_s & ~fifo_full_s & ~lock_q;
    fiu_address    = afu_address[gnt_idx_s];
    fiu_burstcount = afu_burstcount[gnt_idx_s];
    fiu_writedata  = afu_writedata[gnt_idx_s];
    fiu_byteenable = afu_byteenable[gnt_idx_s];
    cmd_s          = fiu_read | fiu_write;
    afu_waitrequest[0] = ~(gnt_vld_s & ~gnt_idx_s & cmd_s) | fiu_waitrequest;
    afu_waitrequest[1] = ~(gnt_vld_s &  gnt_idx_s & cmd_s) | fiu_waitrequest;
    rd_acc_s       = fiu_read  & ~fiu_waitrequest;
    wr_acc_s       = fiu_write & ~fiu_waitrequest;
  end

  // Read return: route each beat to the FIFO head owner, pop on its last beat.
  always_comb begin
    head_owner_s  = fifo_owner_mem[rd_ptr_q];
    head_len_s    = eff_burst(fifo_bc_mem[rd_ptr_q]);
    rd_beat_s     = fiu_readdatavalid & ~fifo_empty_s;
    pop_s         = rd_beat_s & ((beat_cnt_q + BC_ONE) == head_len_s);
    afu_readdata  = fiu_readdata;
    err_unexpected_rd = err_q;
    if (rd_beat_s) begin
      afu_readdatavalid = head_owner_s ? 2'b10 : 2'b01;
    end else begin
      afu_readdatavalid = 2'b00;
    end
  end

  // Next-state computation for lock, hold, round robin, FIFO and error flag.
  always_comb begin
    lock_d        = lock_q;
    lock_owner_d  = lock_owner_q;
    wr_left_d     = wr_left_q;
    last_served_d = last_served_q;
    hold_d        = cmd_s & fiu_waitrequest;
    hold_owner_d  = gnt_idx_s;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q | (fiu_readdatavalid & fifo_empty_s);

    if (wr_acc_s) begin
      if (lock_q) begin
        // Continuation beat of a locked burst.
        wr_left_d = wr_left_q - BC_ONE;
        if (wr_left_q == BC_ONE) begin
          lock_d = 1'b0;
        end else begin
          lock_d = 1'b1;
        end
      end else begin
        last_served_d = gnt_idx_s;
        if (eff_burst(fiu_burstcount) != BC_ONE) begin
          lock_d       = 1'b1;
          lock_owner_d = gnt_idx_s;
          wr_left_d    = eff_burst(fiu_burstcount) - BC_ONE;
        end else begin
          lock_d = 1'b0;
        end
      end
    end else if (rd_acc_s) begin
      last_served_d = gnt_idx_s;
    end else begin
      last_served_d = last_served_q;
    end

    if (rd_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      beat_cnt_d = {BURST_CNT_WIDTH{1'b0}};
    end else if (rd_beat_s) begin
      beat_cnt_d = beat_cnt_q + BC_ONE;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    if (rd_acc_s && !pop_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (pop_s && !rd_acc_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards outstanding reads and any open burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q        <= 1'b0;
      lock_owner_q  <= 1'b0;
      wr_left_q     <= {BURST_CNT_WIDTH{1'b0}};
      hold_q        <= 1'b0;
      hold_owner_q  <= 1'b0;
      last_served_q <= 1'b1;
      cnt_q         <= {CNT_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      beat_cnt_q    <= {BURST_CNT_WIDTH{1'b0}};
      err_q         <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      lock_owner_q  <= lock_owner_d;
      wr_left_q     <= wr_left_d;
      hold_q        <= hold_d;
      hold_owner_q  <= hold_owner_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
    end
  end

  // FIFO storage write on each accepted read command.
  always_ff @(posedge clk) begin
    if (rd_acc_s) begin
      fifo_owner_mem[wr_ptr_q] <= gnt_idx_s;
      fifo_bc_mem[wr_ptr_q]    <= fiu_burstcount;
    end
  end

endmodule
